// File: rtl/reg_id_encoder_pkg.sv
// Shared widths, FSM state encoding and the one-hot helper for the
// register-ID encoder.
package reg_id_encoder_pkg;

    localparam int NUM_REGS = 16;
    localparam int ID_W     = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Wordline form of a register index.
    function automatic logic [NUM_REGS-1:0] id_to_onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REGS-1:0] one_s;
        one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

endpackage

// File: rtl/reg_id_encoder_if.sv
// Mask-in / ID-out handshake bundle. The encoder takes the slave side.
interface reg_id_encoder_if import reg_id_encoder_pkg::*; ();

    logic                req_valid;
    logic [NUM_REGS-1:0] req_mask;
    logic                req_ready;
    logic                flush;
    logic                id_valid;
    logic [ID_W-1:0]     id;
    logic                id_ready;
    logic [NUM_REGS-1:0] id_onehot;
    logic                done;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  req_valid, req_mask, flush, id_ready,
        output req_ready, id_valid, id, id_onehot, done, pending
    );

    modport master (
        output req_valid, req_mask, flush, id_ready,
        input  req_ready, id_valid, id, id_onehot, done, pending
    );

endinterface

// File: rtl/reg_id_encoder_prio_enc.sv
// Lowest-set-bit priority encoder, 16 inputs to a 4-bit index.
module prio_enc_16_4 import reg_id_encoder_pkg::*; (
    input  logic [NUM_REGS-1:0] vec,
    output logic [ID_W-1:0]     idx,
    output logic                any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {ID_W{1'b0}};
        any = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            idx = vec[i] ? ID_W'(i) : idx;
            any = any | vec[i];
        end
    end

endmodule

// File: rtl/reg_id_encoder.sv
// Register-ID encoder: accepts a pending-writeback mask and issues the
// set bits as register IDs in ascending order over a valid/ready port.
// The ID outputs are computed from the next pending set and registered,
// so they never depend combinationally on id_ready or req_valid.
module reg_id_encoder import reg_id_encoder_pkg::*; (
    input logic             clk,
    input logic             rst_n,
    reg_id_encoder_if.slave bus
);

    state_t              state_r;
    logic [NUM_REGS-1:0] pending_r;
    logic                id_valid_r;
    logic [ID_W-1:0]     id_r;
    logic [NUM_REGS-1:0] id_onehot_r;
    logic                done_r;
    logic                req_ready_r;

    logic                xfer_s;
    logic [NUM_REGS-1:0] pend_after_s;
    logic [NUM_REGS-1:0] pend_next_s;
    logic                done_next_s;
    logic [ID_W-1:0]     enc_idx_s;
    logic                enc_any_s;

    // Next pending set: flush wins, IDLE loads a new mask, ISSUE retires the
    // bit just handed to the consumer.
    always_comb begin
        xfer_s       = id_valid_r & bus.id_ready;
        pend_after_s = xfer_s ? (pending_r & ~id_onehot_r) : pending_r;
        pend_next_s  = pending_r;
        done_next_s  = 1'b0;
        if (bus.flush) begin
            pend_next_s = {NUM_REGS{1'b0}};
            done_next_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        pend_next_s = bus.req_mask;
                        done_next_s = (bus.req_mask == {NUM_REGS{1'b0}});
                    end else begin
                        pend_next_s = pending_r;
                        done_next_s = 1'b0;
                    end
                end
                ISSUE: begin
                    pend_next_s = pend_after_s;
                    done_next_s = xfer_s & (pend_after_s == {NUM_REGS{1'b0}});
                end
                default: begin
                    pend_next_s = {NUM_REGS{1'b0}};
                    done_next_s = 1'b0;
                end
            endcase
        end
    end

    prio_enc_16_4 u_prio (
        .vec (pend_next_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // FSM with registered outputs: the ID presented next cycle is the lowest
    // bit of the pending set being stored this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= {NUM_REGS{1'b0}};
            id_valid_r  <= 1'b0;
            id_r        <= {ID_W{1'b0}};
            id_onehot_r <= {NUM_REGS{1'b0}};
            done_r      <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            pending_r   <= pend_next_s;
            done_r      <= done_next_s;
            id_valid_r  <= enc_any_s;
            id_r        <= enc_any_s ? enc_idx_s : {ID_W{1'b0}};
            id_onehot_r <= enc_any_s ? id_to_onehot(enc_idx_s) : {NUM_REGS{1'b0}};
            case (state_r)
                IDLE: begin
                    if (!bus.flush && bus.req_valid && enc_any_s) begin
                        state_r     <= ISSUE;
                        req_ready_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (enc_any_s) begin
                        state_r     <= ISSUE;
                        req_ready_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.id        = id_r;
    assign bus.id_onehot = id_onehot_r;
    assign bus.done      = done_r;
    assign bus.pending   = pending_r;

endmodule

// File: doc/reg_id_encoder.md
REG_ID_ENCODER -- requirements
Module: reg_id_encoder

Interface
REQ-001 SHALL have no parameters; widths come from the shared package (NUM_REGS=16, ID_W=4).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  new register mask offered.
REQ-005 req_mask  in  16  bit i set = register i pending writeback.
REQ-006 req_ready  out  1  block accepts a mask this cycle.
REQ-007 flush  in  1  synchronous abort of current mask.
REQ-008 id_valid  out  1  encoded register ID offered.
REQ-009 id  out  4  encoded register ID.
REQ-010 id_ready  in  1  consumer accepts id.
REQ-011 id_onehot  out  16  one-hot wordline form of id; all-zero when id_valid=0.
REQ-012 done  out  1  one-cycle pulse: mask fully drained.
REQ-013 pending  out  16  remaining un-issued bits (debug/verification).

Function
REQ-014 SHALL implement FSM states IDLE and ISSUE.
REQ-015 IDLE: req_ready=1, id_valid=0; req_valid=1 with nonzero mask loads pending=req_mask, next state ISSUE.
REQ-016 IDLE with req_valid=1 and req_mask=0: mask accepted, stays IDLE, done=1 in the following cycle.
REQ-017 ISSUE: req_ready=0; id_valid=1; id = index of lowest set bit of pending.
REQ-018 Latency: mask accepted at edge N -> id_valid=1 in cycle after edge N (one cycle).
REQ-019 Handshake: transfer occurs when id_valid & id_ready at a rising edge; that bit is cleared from pending.
REQ-020 id, id_onehot, id_valid SHALL stay stable while id_valid=1 and id_ready=0.
REQ-021 id, id_onehot, id_valid SHALL depend only on registered state; no combinational path from id_ready or req_valid.
REQ-022 Back-to-back: with id_ready held 1, one ID transfers per cycle; k set bits drain in k cycles, ascending order.
REQ-023 Final transfer (pending one-hot) -> next state IDLE, done=1 for exactly the next cycle, req_ready=1 that same cycle.
REQ-024 mask=16'hFFFF SHALL issue IDs 0..15; mask with only bit 15 SHALL issue id=4'hF, id_onehot=16'h8000.
REQ-025 flush=1 in any state: pending cleared to 0, next state IDLE, done not asserted; flush overrides req_valid and a simultaneous id handshake (handshake counts as transferred for the consumer; no further IDs).
REQ-026 id_onehot SHALL equal (1 << id) when id_valid=1.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, pending=0, id_valid=0, id=0, id_onehot=0, done=0; req_ready=1 while in IDLE.
REQ-028 Reset mid-ISSUE SHALL discard remaining pending bits without a done pulse.
REQ-029 First mask accepted on first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold NUM_REGS, ID_W and the FSM state enum (IDLE, ISSUE).
REQ-031 Lowest-set-bit 16->4 priority encoding SHALL be a separate sub-module prio_enc_16_4 (combinational, input 16-bit vector, outputs 4-bit index and any-set flag).

Verification
REQ-032 mask=16'h0000 in IDLE -> no id_valid, done=1 next cycle, req_ready stays 1.
REQ-033 mask=16'h8421, id_ready=1 constant -> ids 0,5,10,15 on consecutive cycles, done one cycle after id=15 transfer.
REQ-034 mask=16'h0006, id_ready=0 for 3 cycles then 1 -> id=1 held stable 3 cycles, then id=2, then done.
REQ-035 mask=16'hFFFF, flush asserted after 4 transfers -> ids 0..3 seen, IDLE next cycle, pending=0, no done.
REQ-036 mask=16'h00F0, rst_n low after first transfer -> outputs zero asynchronously, no done; new mask 16'h0001 after release -> id=0, id_onehot=16'h0001.
